// File: rtl/spi_enc_pkg.sv
// Shared definitions for the dual quadrature-encoder SPI master.
// Contents: top FSM state type, command/filler bytes and transfer geometry.
package spi_enc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } spi_state_t;

  localparam logic [7:0]  CMD_READ_ALL   = 8'h00;
  localparam logic [7:0]  FILLER_BYTE    = 8'h00;
  localparam int unsigned NUM_DATA_BYTES = 8;
  localparam int unsigned BITS_PER_BYTE  = 8;
  // Address byte followed by the data bytes.
  localparam int unsigned NUM_XFER_BYTES = NUM_DATA_BYTES + 1;

endpackage

// File: rtl/spi_master_byte.sv
// One-byte SPI mode-0 shift engine with sck divider.
// Ports:
//   clk, resetN     : system clock, asynchronous active-low reset
//   go              : level; start (when idle) or continue with the next byte
//                     at the end of the current one; low at a byte end stops
//   txByte          : byte to shift out (loaded when idle or at a byte end)
//   miso            : raw peripheral data, 2-flop synchronised here
//   rxByte          : received byte, valid while byteDone is high
//   byteDone        : high in the cycle that ends with the byte's last sck fall
//   sck, mosi       : SPI clock (idles low) and master data (MSB first)
module spi_master_byte
  import spi_enc_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       go,
  input  logic [7:0] txByte,
  input  logic       miso,
  output logic [7:0] rxByte,
  output logic       byteDone,
  output logic       sck,
  output logic       mosi
);

  localparam int unsigned     DIV_W     = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] SAMPLE_AT = DIV_W'(1);
  localparam logic [2:0]       BIT_LAST = 3'(BITS_PER_BYTE - 1);

  logic             active;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sh;
  logic [7:0]       rx_sh;
  logic [7:0]       rx_next;
  logic             miso_s1;
  logic             miso_s2;
  logic             phase_end;
  logic             sample;

  assign phase_end = active && (div_cnt == DIV_LAST);
  // Synchroniser adds two cycles, so sample two cycles into the high phase.
  assign sample    = active && sck && (div_cnt == SAMPLE_AT);
  assign byteDone  = phase_end && sck && (bit_cnt == BIT_LAST);
  assign mosi      = tx_sh[7];

  // With CLK_DIV=2 the last sample lands on the final falling edge, so the
  // byte is presented with the in-flight bit already merged.
  always_comb begin
    rx_next = rx_sh;
    if (sample) rx_next = {rx_sh[6:0], miso_s2};
  end
  assign rxByte = rx_next;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sck     <= 1'b0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
    end else begin
      miso_s1 <= miso;
      miso_s2 <= miso_s1;
      rx_sh   <= rx_next;
      if (!active) begin
        sck     <= 1'b0;
        div_cnt <= '0;
        bit_cnt <= '0;
        tx_sh   <= txByte;
        if (go) active <= 1'b1;
      end else if (phase_end) begin
        div_cnt <= '0;
        if (!sck) begin
          sck <= 1'b1;
        end else begin
          sck <= 1'b0;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (go) tx_sh  <= txByte;
            else    active <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            tx_sh   <= {tx_sh[6:0], 1'b0};
          end
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_encoder_master.sv
// Master-side SPI reader for the dual quadrature-encoder peripheral.
// Each transaction sends start address 0x00, reads 8 frozen bytes and
// publishes countA = {b1..b4}, countB = {b5..b8} together with a done pulse.
// Optional feature: define SPI_ENC_MASTER_AUTO_POLL_EN to start a transaction
// every POLL_PERIOD cycles (measured from the previous accept).
// Ports:
//   clk, resetN     : system clock, asynchronous active-low reset
//   start           : transaction request, sampled only in IDLE
//   busy            : high from the cycle after accept until GAP ends
//   done            : one-cycle pulse when countA/countB update
//   countA, countB  : encoder 0 / encoder 1 counts
//   cs, sck, mosi   : SPI chip select (active-low), clock, master data
//   miso            : asynchronous peripheral data
module spi_encoder_master
  import spi_enc_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned CS_SETUP    = 2,
  parameter int unsigned CS_IDLE     = 8,
  parameter int unsigned POLL_PERIOD = 4096
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] countA,
  output logic [31:0] countB,
  output logic        cs,
  output logic        sck,
  output logic        mosi,
  input  logic        miso
);

  localparam int unsigned      HOLD_W   = NUM_DATA_BYTES * BITS_PER_BYTE;
  localparam int unsigned      SET_W    = $clog2(CS_SETUP + 1);
  localparam int unsigned      GAP_W    = $clog2(CS_IDLE + 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(CS_SETUP - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_IDLE - 1);
  localparam logic [3:0]       BYTE_LAST   = 4'(NUM_XFER_BYTES - 1);
  localparam logic [3:0]       BYTE_PENULT = 4'(NUM_XFER_BYTES - 2);

  if (CLK_DIV < 2 || CS_SETUP < 1 || CS_IDLE < 1 || POLL_PERIOD < 1) begin : g_param_check
    $error("spi_encoder_master: CLK_DIV must be >= 2; CS_SETUP, CS_IDLE, POLL_PERIOD >= 1");
  end

  spi_state_t        state;
  logic [SET_W-1:0]  setup_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [3:0]        byte_cnt;
  logic [HOLD_W-1:0] hold;
  logic              go;
  logic [7:0]        tx_byte;
  logic [7:0]        rx_byte;
  logic              byte_done;
  logic              start_req;

`ifdef SPI_ENC_MASTER_AUTO_POLL_EN
  localparam int unsigned     POLL_W    = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_PERIOD - 1);

  logic [POLL_W-1:0] poll_cnt;
  logic              poll_tick;

  assign poll_tick = (poll_cnt == POLL_LAST);
  assign start_req = start | poll_tick;

  // Restarts on every accept; a tick that arrives while busy is simply lost.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      poll_cnt <= '0;
    end else if (((state == IDLE) && start_req) || poll_tick) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + POLL_W'(1);
    end
  end
`else
  assign start_req = start;
`endif

  // Engine reloads at byte ends only during XFER, so every byte after the
  // address is filler.
  assign tx_byte = (state == XFER) ? FILLER_BYTE : CMD_READ_ALL;

  spi_master_byte #(
    .CLK_DIV (CLK_DIV)
  ) u_byte (
    .clk      (clk),
    .resetN   (resetN),
    .go       (go),
    .txByte   (tx_byte),
    .miso     (miso),
    .rxByte   (rx_byte),
    .byteDone (byte_done),
    .sck      (sck),
    .mosi     (mosi)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      cs        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      countA    <= '0;
      countB    <= '0;
      go        <= 1'b0;
      setup_cnt <= '0;
      gap_cnt   <= '0;
      byte_cnt  <= '0;
      hold      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cs <= 1'b1;
          if (start_req) begin
            state     <= SETUP;
            cs        <= 1'b0;
            busy      <= 1'b1;
            setup_cnt <= '0;
            byte_cnt  <= '0;
            hold      <= '0;
          end
        end
        SETUP: begin
          if (setup_cnt == SET_LAST) begin
            state <= XFER;
            go    <= 1'b1;
          end else begin
            setup_cnt <= setup_cnt + SET_W'(1);
          end
        end
        XFER: begin
          if (byte_done) begin
            if (byte_cnt != 4'd0) hold <= {hold[HOLD_W-BITS_PER_BYTE-1:0], rx_byte};
            // go is dropped one byte early: the engine reads it at the end of
            // each byte to decide whether to continue.
            if (byte_cnt == BYTE_PENULT) go <= 1'b0;
            if (byte_cnt == BYTE_LAST) state <= HOLD;
            else                       byte_cnt <= byte_cnt + 4'd1;
          end
        end
        HOLD: begin
          cs      <= 1'b1;
          countA  <= hold[HOLD_W-1:HOLD_W/2];
          countB  <= hold[HOLD_W/2-1:0];
          done    <= 1'b1;
          gap_cnt <= '0;
          state   <= GAP;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_encoder_master.sv
// Self-checking bench for spi_encoder_master with a behavioural peripheral.
module tb_spi_encoder_master;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_IDLE  = 8;
  localparam int LAT  = 1 + CS_SETUP + 144 * CLK_DIV + 1;
  localparam int LAT2 = 1 + CS_SETUP + 144 * 2 + 1;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic busy, done, cs, sck, mosi, miso;
  logic busy2, done2, cs2, sck2, mosi2, miso2_d;
  logic [31:0] countA, countB, countA2, countB2;

  always #5 clk = ~clk;

  spi_encoder_master #(
    .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_IDLE(CS_IDLE), .POLL_PERIOD(1000)
  ) dut (
    .clk(clk), .resetN(resetN), .start(start), .busy(busy), .done(done),
    .countA(countA), .countB(countB), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso)
  );

  spi_encoder_master #(
    .CLK_DIV(2), .CS_SETUP(CS_SETUP), .CS_IDLE(CS_IDLE), .POLL_PERIOD(1000)
  ) dut2 (
    .clk(clk), .resetN(resetN), .start(start2), .busy(busy2), .done(done2),
    .countA(countA2), .countB(countB2), .cs(cs2), .sck(sck2), .mosi(mosi2), .miso(miso2_d)
  );

  // Peripheral models: snapshot on cs fall, shift on sck fall (mode 0).
  logic [31:0] encA = 32'h0, encB = 32'h0, encA2 = 32'h0, encB2 = 32'h0;
  logic [71:0] sh1 = '0, sh2 = '0;
  logic cs_q = 1'b1, sck_q = 1'b0, cs2_q = 1'b1, sck2_q = 1'b0;
  int cyc_ctr = 0, rises1 = 0, mosi_ones = 0, cs_rises = 0, done_cnt = 0;
  int cs_fall_cyc = 0, done_cyc = 0, prev_done_cyc = 0;
  int rise2_last = 0, rise2_prev = 0, mosi2_ones = 0;

  assign miso = sh1[71];
  always @(posedge clk) miso2_d <= sh2[71];

  always @(negedge clk) begin
    cyc_ctr <= cyc_ctr + 1;
    if (cs_q && !cs) begin
      sh1 <= {8'h00, encA, encB};
      cs_fall_cyc <= cyc_ctr;
    end else if (!cs && sck_q && !sck) begin
      sh1 <= {sh1[70:0], 1'b0};
    end
    if (!cs && !sck_q && sck) begin
      rises1 <= rises1 + 1;
      if (mosi) mosi_ones <= mosi_ones + 1;
    end
    if (!cs_q && cs) cs_rises <= cs_rises + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc_ctr;
      prev_done_cyc <= done_cyc;
    end
    if (cs2_q && !cs2) sh2 <= {8'h00, encA2, encB2};
    else if (!cs2 && sck2_q && !sck2) sh2 <= {sh2[70:0], 1'b0};
    if (!cs2 && !sck2_q && sck2) begin
      rise2_last <= cyc_ctr;
      rise2_prev <= rise2_last;
      if (mosi2) mosi2_ones <= mosi2_ones + 1;
    end
    cs_q <= cs; sck_q <= sck; cs2_q <= cs2; sck2_q <= sck2;
  end

  logic [63:0] exp_q[$];
  logic [63:0] exp_q2[$];
  logic [63:0] expv;
  int total = 0;
  int bad = 0;

  task automatic wait_done(input bit sel, input int budget, output int cyc, output bit seen);
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < budget) begin
      @(posedge clk);
      cyc++;
      #1;
      if (sel ? done2 : done) seen = 1'b1;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (cs !== 1'b1)     begin bad++; $display("FAIL reset_cs: got %b want 1", cs); end
    total++; if (sck !== 1'b0)    begin bad++; $display("FAIL reset_sck: got %b want 0", sck); end
    total++; if (mosi !== 1'b0)   begin bad++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (countA !== 32'h0) begin bad++; $display("FAIL reset_countA: got %h want 0", countA); end
    total++; if (countB !== 32'h0) begin bad++; $display("FAIL reset_countB: got %h want 0", countB); end
    resetN = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_read();
    int cyc; bit seen; int r0, m0;
    wait_idle();
    encA = 32'h12345678; encB = 32'hFEDCBA98;
    r0 = rises1; m0 = mosi_ones;
    exp_q.push_back({encA, encB});
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_done(1'b0, LAT + 50, cyc, seen);
    total++; if (!seen || cyc != LAT) begin bad++; $display("FAIL basic_latency: got %0d (seen=%0b) want %0d", cyc, seen, LAT); end
    expv = exp_q.pop_front();
    total++; if (countA !== expv[63:32]) begin bad++; $display("FAIL basic_countA: got %h want %h", countA, expv[63:32]); end
    total++; if (countB !== expv[31:0])  begin bad++; $display("FAIL basic_countB: got %h want %h", countB, expv[31:0]); end
    total++; if (cs !== 1'b1) begin bad++; $display("FAIL basic_cs_at_done: got %b want 1", cs); end
    total++; if (rises1 - r0 != 72) begin bad++; $display("FAIL basic_sck_rises: got %0d want 72", rises1 - r0); end
    total++; if (mosi_ones - m0 != 0) begin bad++; $display("FAIL basic_mosi_zero: got %0d ones want 0", mosi_ones - m0); end
  endtask

  task automatic test_frozen();
    int cyc; bit seen; int hi;
    wait_idle();
    encA = 32'h00000001;
    exp_q.push_back({encA, encB});
    pulse_start();
    repeat (100) @(posedge clk);
    encA = 32'h00000002;
    wait_done(1'b0, LAT + 50, cyc, seen);
    expv = exp_q.pop_front();
    total++; if (!seen || countA !== expv[63:32]) begin bad++; $display("FAIL frozen_countA: got %h (seen=%0b) want %h", countA, seen, expv[63:32]); end
    // Hold start high: next transaction follows GAP directly.
    exp_q.push_back({encA, encB});
    start = 1'b1;
    hi = 0;
    while (cs === 1'b1 && hi < 100) begin
      @(negedge clk);
      if (cs) hi++;
    end
    start = 1'b0;
    total++; if (hi < int'(CS_IDLE) || hi > int'(CS_IDLE) + 2) begin bad++; $display("FAIL frozen_cs_high: got %0d cycles want %0d..%0d", hi, CS_IDLE, CS_IDLE + 2); end
    wait_done(1'b0, LAT + 50, cyc, seen);
    expv = exp_q.pop_front();
    total++; if (!seen || countA !== expv[63:32]) begin bad++; $display("FAIL frozen_next_countA: got %h (seen=%0b) want %h", countA, seen, expv[63:32]); end
    total++; if (countB !== expv[31:0]) begin bad++; $display("FAIL frozen_next_countB: got %h want %h", countB, expv[31:0]); end
  endtask

  task automatic test_busy_restart();
    int cyc; bit seen; int d0, c0;
    wait_idle();
    encA = 32'h0BADF00D; encB = 32'h55AA33CC;
    exp_q.push_back({encA, encB});
    d0 = done_cnt; c0 = cs_rises;
    pulse_start();
    repeat (99) @(posedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(1'b0, LAT + 50, cyc, seen);
    expv = exp_q.pop_front();
    total++; if (!seen || countA !== expv[63:32] || countB !== expv[31:0]) begin bad++; $display("FAIL restart_counts: got %h_%h (seen=%0b) want %h", countA, countB, seen, expv); end
    repeat (700) @(negedge clk);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL restart_done_pulses: got %0d want 1", done_cnt - d0); end
    total++; if (cs_rises - c0 != 1) begin bad++; $display("FAIL restart_cs_rises: got %0d want 1", cs_rises - c0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL restart_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int cyc; bit seen; int d0;
    wait_idle();
    d0 = done_cnt;
    pulse_start();
    // Engine starts 1+CS_SETUP cycles after accept; bit 30 begins 240 later.
    repeat (1 + CS_SETUP + 30 * 2 * CLK_DIV + 2) @(posedge clk);
    #2 resetN = 1'b0;
    #1;
    total++; if (cs !== 1'b1)  begin bad++; $display("FAIL midrst_cs: got %b want 1", cs); end
    total++; if (sck !== 1'b0) begin bad++; $display("FAIL midrst_sck: got %b want 0", sck); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if (countA !== 32'h0 || countB !== 32'h0) begin bad++; $display("FAIL midrst_counts: got %h_%h want 0", countA, countB); end
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    repeat (700) @(negedge clk);
    total++; if (done_cnt != d0) begin bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - d0); end
    encA = 32'hA5A50F0F; encB = 32'h00000001;
    exp_q.push_back({encA, encB});
    pulse_start();
    wait_done(1'b0, LAT + 50, cyc, seen);
    expv = exp_q.pop_front();
    total++; if (!seen || cyc != LAT) begin bad++; $display("FAIL midrst_latency: got %0d (seen=%0b) want %0d", cyc, seen, LAT); end
    total++; if (countA !== expv[63:32] || countB !== expv[31:0]) begin bad++; $display("FAIL midrst_counts_after: got %h_%h want %h", countA, countB, expv); end
  endtask

  task automatic test_clkdiv2();
    int cyc; bit seen; int m0;
    encA2 = 32'hCAFEBABE; encB2 = 32'h01234567;
    m0 = mosi2_ones;
    exp_q2.push_back({encA2, encB2});
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL div2_busy: got %b want 1", busy2); end
    wait_done(1'b1, LAT2 + 50, cyc, seen);
    total++; if (!seen || cyc != LAT2) begin bad++; $display("FAIL div2_latency: got %0d (seen=%0b) want %0d", cyc, seen, LAT2); end
    expv = exp_q2.pop_front();
    total++; if (countA2 !== expv[63:32] || countB2 !== expv[31:0]) begin bad++; $display("FAIL div2_counts: got %h_%h want %h", countA2, countB2, expv); end
    total++; if (rise2_last - rise2_prev != 4) begin bad++; $display("FAIL div2_sck_period: got %0d want 4", rise2_last - rise2_prev); end
    total++; if (mosi2_ones - m0 != 0) begin bad++; $display("FAIL div2_mosi_zero: got %0d ones want 0", mosi2_ones - m0); end
  endtask

  task automatic test_auto_poll();
    int cyc; bit seen;
    start = 1'b0;
    encA = 32'h13572468; encB = 32'h89ABCDEF;
    exp_q.push_back({encA, encB});
    exp_q.push_back({encA, encB});
    wait_done(1'b0, 2500, cyc, seen);
    expv = exp_q.pop_front();
    total++; if (!seen || countA !== expv[63:32] || countB !== expv[31:0]) begin bad++; $display("FAIL poll_first: got %h_%h (seen=%0b) want %h", countA, countB, seen, expv); end
    wait_done(1'b0, 1500, cyc, seen);
    @(negedge clk); #1;
    expv = exp_q.pop_front();
    total++; if (!seen || countA !== expv[63:32] || countB !== expv[31:0]) begin bad++; $display("FAIL poll_second: got %h_%h (seen=%0b) want %h", countA, countB, seen, expv); end
    total++; if (done_cyc - prev_done_cyc != 1000) begin bad++; $display("FAIL poll_spacing: got %0d want 1000", done_cyc - prev_done_cyc); end
    total++; if (done_cyc - cs_fall_cyc != LAT) begin bad++; $display("FAIL poll_latency: got %0d want %0d", done_cyc - cs_fall_cyc, LAT); end
  endtask

  initial begin
    test_reset();
`ifdef SPI_ENC_MASTER_AUTO_POLL_EN
    test_auto_poll();
`else
    test_basic_read();
    test_frozen();
    test_busy_restart();
    test_reset_mid();
    test_clkdiv2();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
